// File: rtl/block_bx_fanout.sv
// Routes (or broadcasts) one rdy/vld input stream into per-output FIFOs and
// periodically reports accept/drop statistics over a 4-phase req/ack channel.
module block_bx_fanout #(
    parameter int N_OUT    = 2,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int MODE     = 0,
    parameter int REPORT_N = 16,
    localparam int DW      = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [DW-1:0]           in_dest,
    output logic [N_OUT-1:0]        out_vld,
    input  logic [N_OUT-1:0]        out_rdy,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic                    c_req,
    input  logic                    c_ack,
    output logic [15:0]             c_data
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } rpt_state_t;

    logic [DATA_W-1:0] mem_q  [N_OUT][DEPTH];
    logic [AW:0]       wptr_q [N_OUT];
    logic [AW:0]       wptr_d [N_OUT];
    logic [AW:0]       rptr_q [N_OUT];
    logic [AW:0]       rptr_d [N_OUT];

    logic [N_OUT-1:0] full;
    logic [N_OUT-1:0] empty;
    logic [N_OUT-1:0] push;
    logic [N_OUT-1:0] pop;

    logic       dest_ok;
    logic       accept;
    logic       drop;
    logic       rpt_evt;
    logic [7:0] acc_cnt_q, acc_cnt_d;
    logic [7:0] rpt_cnt_q, rpt_cnt_d;
    logic [6:0] drop_cnt_q, drop_cnt_d;
    logic [6:0] drop_cnt_inc;
    logic       ovr_q, ovr_d;
    logic [15:0] c_data_q, c_data_d;
    rpt_state_t state_q, state_d;

    function automatic logic [6:0] sat_inc7(input logic [6:0] v);
        return (v == 7'h7f) ? v : v + 7'd1;
    endfunction

    // FIFO status comes from registered pointers only, so a same-cycle pop never frees a slot early
    always_comb begin
        for (int i = 0; i < N_OUT; i++) begin
            empty[i] = (wptr_q[i] == rptr_q[i]);
            full[i]  = (wptr_q[i][AW] != rptr_q[i][AW]) &&
                       (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]);
        end
    end

    always_comb begin
        dest_ok = (int'(in_dest) < N_OUT);
        if (MODE == 1) begin
            in_rdy = ~|full;
        end else begin
            in_rdy = 1'b1;
            for (int i = 0; i < N_OUT; i++) begin
                if (int'(in_dest) == i) in_rdy = !full[i];
            end
        end
        accept = in_vld & in_rdy;
        drop   = accept && (MODE == 0) && !dest_ok;
    end

    always_comb begin
        for (int i = 0; i < N_OUT; i++) begin
            push[i]   = accept && ((MODE == 1) || (int'(in_dest) == i));
            pop[i]    = !empty[i] && out_rdy[i];
            wptr_d[i] = wptr_q[i] + {{AW{1'b0}}, push[i]};
            rptr_d[i] = rptr_q[i] + {{AW{1'b0}}, pop[i]};
        end
    end

    assign out_vld = ~empty;

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign out_data[g*DATA_W +: DATA_W] = mem_q[g][rptr_q[g][AW-1:0]];
    end

    // Payload storage carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_OUT; i++) begin
            if (push[i]) mem_q[i][wptr_q[i][AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_OUT; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
            end
        end
    end

    always_comb begin
        acc_cnt_d    = acc_cnt_q + {7'd0, accept};
        rpt_evt      = accept && (rpt_cnt_q == 8'(REPORT_N - 1));
        rpt_cnt_d    = rpt_cnt_q;
        if (accept) rpt_cnt_d = rpt_evt ? 8'd0 : rpt_cnt_q + 8'd1;
        drop_cnt_inc = drop ? sat_inc7(drop_cnt_q) : drop_cnt_q;

        drop_cnt_d = drop_cnt_inc;
        ovr_d      = ovr_q;
        c_data_d   = c_data_q;
        state_d    = state_q;
        case (state_q)
            ST_IDLE: begin
                // A drop on the triggering beat is already folded into drop_cnt_inc
                if (rpt_evt) begin
                    c_data_d   = {ovr_q, drop_cnt_inc, acc_cnt_d};
                    drop_cnt_d = 7'd0;
                    ovr_d      = 1'b0;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (rpt_evt) ovr_d = 1'b1;
                if (c_ack) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (rpt_evt) ovr_d = 1'b1;
                if (!c_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_q  <= 8'd0;
            rpt_cnt_q  <= 8'd0;
            drop_cnt_q <= 7'd0;
            ovr_q      <= 1'b0;
            c_data_q   <= 16'd0;
            state_q    <= ST_IDLE;
        end else begin
            acc_cnt_q  <= acc_cnt_d;
            rpt_cnt_q  <= rpt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ovr_q      <= ovr_d;
            c_data_q   <= c_data_d;
            state_q    <= state_d;
        end
    end

    assign c_req  = (state_q == ST_REQ);
    assign c_data = c_data_q;

endmodule

// File: tb/tb_block_bx_fanout.sv
// Two instances share one input stream: routed (N_OUT=3, REPORT_N=4) and
// broadcast (N_OUT=3, REPORT_N=1); both are compared to a queue-based model.
module tb_block_bx_fanout;

    localparam int N     = 3;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_vld = 1'b0;
    logic [31:0] in_data = '0;
    logic [1:0]  in_dest = '0;
    logic [2:0]  out_rdy = '0;
    logic        c_ack = 1'b0;

    logic        in_rdy0, in_rdy1;
    logic [2:0]  out_vld0, out_vld1;
    logic [95:0] out_data0, out_data1;
    logic        c_req0, c_req1;
    logic [15:0] c_data0, c_data1;

    int total = 0;
    int bad   = 0;

    // Reference state: queues 0..2 for the routed instance, 3..5 for broadcast
    logic [31:0] q [0:5][$];
    int          rptc [2];
    logic [7:0]  acc  [2];
    logic [6:0]  drp  [2];
    logic        ovr  [2];
    int          ph   [2];
    logic [15:0] cd   [2];

    always #5 clk = ~clk;

    block_bx_fanout #(.N_OUT(N), .DATA_W(32), .DEPTH(DEPTH), .MODE(0), .REPORT_N(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy0), .in_data(in_data),
        .in_dest(in_dest), .out_vld(out_vld0), .out_rdy(out_rdy), .out_data(out_data0),
        .c_req(c_req0), .c_ack(c_ack), .c_data(c_data0)
    );

    block_bx_fanout #(.N_OUT(N), .DATA_W(32), .DEPTH(DEPTH), .MODE(1), .REPORT_N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy1), .in_data(in_data),
        .in_dest(in_dest), .out_vld(out_vld1), .out_rdy(out_rdy), .out_data(out_data1),
        .c_req(c_req1), .c_ack(c_ack), .c_data(c_data1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic get_rdy(input int k);
        return (k == 0) ? in_rdy0 : in_rdy1;
    endfunction

    function automatic logic [2:0] get_vld(input int k);
        return (k == 0) ? out_vld0 : out_vld1;
    endfunction

    function automatic logic [31:0] get_data(input int k, input int i);
        logic [95:0] v;
        v = (k == 0) ? out_data0 : out_data1;
        return v[i*32 +: 32];
    endfunction

    function automatic logic m_rdy(input int k);
        if (k == 1)
            return (q[3].size() < DEPTH) && (q[4].size() < DEPTH) && (q[5].size() < DEPTH);
        if (in_dest == 2'd3) return 1'b1;
        return q[in_dest].size() < DEPTH;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) q[i].delete();
        for (int k = 0; k < 2; k++) begin
            rptc[k] = 0; acc[k] = '0; drp[k] = '0; ovr[k] = 1'b0; ph[k] = 0; cd[k] = '0;
        end
    endtask

    task automatic check_all();
        logic [2:0] ev;
        for (int k = 0; k < 2; k++) begin
            ev = '0;
            for (int i = 0; i < N; i++) begin
                ev[i] = (q[k*3+i].size() > 0);
                if (ev[i]) chk($sformatf("d%0d_data%0d", k, i), get_data(k, i), q[k*3+i][0]);
            end
            chk($sformatf("d%0d_out_vld", k), get_vld(k), ev);
            chk($sformatf("d%0d_in_rdy", k), get_rdy(k), m_rdy(k));
            chk($sformatf("d%0d_c_req", k), (k == 0) ? c_req0 : c_req1, ph[k] == 1);
            chk($sformatf("d%0d_c_data", k), (k == 0) ? c_data0 : c_data1, cd[k]);
        end
    endtask

    // Applies what the coming rising edge does, from the inputs now stable
    task automatic model_edge();
        logic       a;
        logic       evt;
        logic [6:0] dn;
        int         rn;
        for (int k = 0; k < 2; k++) begin
            a = in_vld && m_rdy(k);
            for (int i = 0; i < N; i++)
                if (q[k*3+i].size() > 0 && out_rdy[i]) void'(q[k*3+i].pop_front());
            if (a) begin
                if (k == 1) for (int i = 0; i < N; i++) q[3+i].push_back(in_data);
                else if (in_dest != 2'd3) q[in_dest].push_back(in_data);
            end
            rn  = (k == 0) ? 4 : 1;
            evt = a && (rptc[k] == rn - 1);
            if (a) begin
                rptc[k] = evt ? 0 : rptc[k] + 1;
                acc[k]  = acc[k] + 8'd1;
            end
            dn = drp[k];
            if (a && k == 0 && in_dest == 2'd3 && dn != 7'd127) dn = dn + 7'd1;
            if (ph[k] == 0 && evt) begin
                cd[k] = {ovr[k], dn, acc[k]};
                drp[k] = '0; ovr[k] = 1'b0; ph[k] = 1;
            end else begin
                drp[k] = dn;
                if (evt) ovr[k] = 1'b1;
                if (ph[k] == 1 && c_ack) ph[k] = 2;
                else if (ph[k] == 2 && !c_ack) ph[k] = 0;
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] d, input logic [1:0] dest,
                         input logic [2:0] rdy, input logic ack);
        @(negedge clk);
        in_vld = v; in_data = d; in_dest = dest; out_rdy = rdy; c_ack = ack;
        #1;
        check_all();
        model_edge();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0; in_vld = 1'b0; out_rdy = '0; c_ack = 1'b0;
        #1;
        chk("rst_out_vld0", out_vld0, 3'b000);
        chk("rst_out_vld1", out_vld1, 3'b000);
        chk("rst_c_req0", c_req0, 1'b0);
        chk("rst_c_req1", c_req1, 1'b0);
        chk("rst_in_rdy0", in_rdy0, 1'b1);
        chk("rst_in_rdy1", in_rdy1, 1'b1);
        chk("rst_c_data0", c_data0, 16'h0000);
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // routed delivery: one pulse per channel, one cycle after accept
        for (int j = 0; j < 4; j++) begin
            cycle(j < 3, 32'hA000_0000 + j, 2'(j), 3'b111, 1'b0);
            if (j > 0) begin
                chk("route_vld", out_vld0, 32'd1 << (j - 1));
                chk("route_data", out_data0[(j-1)*32 +: 32], 32'hA000_0000 + j - 1);
            end
        end
        cycle(1'b0, '0, 2'd0, 3'b111, 1'b0);
        chk("route_idle", out_vld0, 3'b000);

        // per-output backpressure on channel 1
        do_reset();
        for (int j = 0; j < 4; j++) cycle(1'b1, 32'hB000_0000 + j, 2'd1, 3'b101, 1'b0);
        cycle(1'b1, 32'hB000_0004, 2'd1, 3'b101, 1'b0);
        chk("bp_full_rdy", in_rdy0, 1'b0);
        cycle(1'b1, 32'hC000_0000, 2'd0, 3'b101, 1'b0);
        chk("bp_other_rdy", in_rdy0, 1'b1);
        cycle(1'b0, '0, 2'd0, 3'b101, 1'b0);
        chk("bp_other_data", out_data0[31:0], 32'hC000_0000);
        for (int j = 0; j < 4; j++) begin
            cycle(1'b0, '0, 2'd0, 3'b111, 1'b0);
            chk("bp_drain_data", out_data0[63:32], 32'hB000_0000 + j);
        end
        cycle(1'b1, 32'hB000_0004, 2'd1, 3'b111, 1'b0);
        cycle(1'b0, '0, 2'd0, 3'b111, 1'b0);
        chk("bp_drain_last", out_data0[63:32], 32'hB000_0004);

        // broadcast: a single stalled output blocks the input
        do_reset();
        for (int j = 0; j < 4; j++) cycle(1'b1, 32'hD000_0000 + j, 2'd0, 3'b011, 1'b0);
        cycle(1'b0, '0, 2'd0, 3'b011, 1'b0);
        cycle(1'b0, '0, 2'd0, 3'b011, 1'b0);
        chk("bc_stall_rdy", in_rdy1, 1'b0);
        chk("bc_stall_vld", out_vld1, 3'b100);
        cycle(1'b0, '0, 2'd0, 3'b111, 1'b0);
        chk("bc_pop_same_cycle", in_rdy1, 1'b0);
        cycle(1'b0, '0, 2'd0, 3'b011, 1'b0);
        chk("bc_after_pop", in_rdy1, 1'b1);

        // invalid destinations are dropped and counted in the report
        do_reset();
        for (int j = 0; j < 4; j++) begin
            cycle(1'b1, 32'hE000_0000 + j, (j < 3) ? 2'd3 : 2'd0, 3'b111, 1'b0);
            if (j > 0) chk("inv_no_vld", out_vld0, 3'b000);
        end
        cycle(1'b0, '0, 2'd0, 3'b111, 1'b0);
        chk("inv_c_req", c_req0, 1'b1);
        chk("inv_c_data", c_data0, 16'h0304);
        chk("inv_valid_vld", out_vld0, 3'b001);
        cycle(1'b0, '0, 2'd0, 3'b111, 1'b0);
        cycle(1'b0, '0, 2'd0, 3'b111, 1'b1);
        chk("rpt_hold", c_req0, 1'b1);
        cycle(1'b0, '0, 2'd0, 3'b111, 1'b0);
        chk("rpt_ack_drop", c_req0, 1'b0);

        // overrun while a report is outstanding sets the sticky bit
        do_reset();
        cycle(1'b1, 32'hF000_0000, 2'd0, 3'b111, 1'b0);
        cycle(1'b1, 32'hF000_0001, 2'd0, 3'b111, 1'b0);
        chk("ovr_first_req", c_req1, 1'b1);
        chk("ovr_first_data", c_data1, 16'h0001);
        cycle(1'b0, '0, 2'd0, 3'b111, 1'b1);
        cycle(1'b0, '0, 2'd0, 3'b111, 1'b0);
        chk("ovr_req_low", c_req1, 1'b0);
        cycle(1'b1, 32'hF000_0002, 2'd0, 3'b111, 1'b0);
        cycle(1'b0, '0, 2'd0, 3'b111, 1'b0);
        chk("ovr_second_req", c_req1, 1'b1);
        chk("ovr_second_data", c_data1, 16'h8003);

        // reset with FIFOs partly full and a report outstanding
        cycle(1'b1, 32'h1234_0000, 2'd1, 3'b000, 1'b0);
        cycle(1'b1, 32'h1234_0001, 2'd2, 3'b000, 1'b0);
        chk("pre_rst_req", c_req1, 1'b1);
        do_reset();

        for (int n = 0; n < 800; n++)
            cycle(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        cycle(1'b0, '0, 2'd0, 3'b111, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
